// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU: opcodes, instruction field positions
// and the fetch FSM state encoding.
package cpu16_pkg;

  localparam logic [1:0] OP_R    = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_LW   = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;

  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 14;
  localparam int RS_HI     = 13;
  localparam int RS_LO     = 12;
  localparam int RT_HI     = 11;
  localparam int RT_LO     = 10;
  localparam int RD_HI     = 9;
  localparam int RD_LO     = 8;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    HOLD  = 2'b10,
    FLUSH = 2'b11
  } fetchState_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: reset load, redirect load (highest priority after
// reset) and increment. pcNext exposes the value the register takes next edge.
module pc_counter
  import cpu16_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadEn,
  input  logic [ADDR_W-1:0] loadValue,
  input  logic              incEn,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcNext
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  always_comb begin
    pcNext = pc;
    if (loadEn) begin
      pcNext = loadValue;
    end else if (incEn) begin
      pcNext = pc + INC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pcNext;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the imem request/ack handshake, captures the fetched word
// into the instruction register and hands it to decode via valid/ready.
module instr_fetch
  import cpu16_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [1:0]        opcode,
  output logic [1:0]        rs,
  output logic [1:0]        rt,
  output logic [1:0]        rd,
  output logic [7:0]        imm
);

  fetchState_t       state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcNext;
  logic              incEn;

  // The PC only advances when a non-redirected fetch completes.
  assign incEn = (state == REQ) && imem_ack;

  pc_counter #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .PC_INC  (PC_INC)
  ) pcCounter (
    .clk      (clk),
    .reset    (reset),
    .loadEn   (redirect),
    .loadValue(redirect_pc),
    .incEn    (incEn),
    .pc       (pc),
    .pcNext   (pcNext)
  );

  // New requests always target pcNext so a same-cycle redirect is honoured.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      out_valid <= 1'b0;
      instr     <= '0;
      instr_pc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pcNext;
          end
        end
        REQ: begin
          if (imem_ack && redirect) begin
            if (fetch_en) begin
              state     <= REQ;
              imem_addr <= pcNext;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end else if (imem_ack) begin
            instr     <= imem_rdata;
            instr_pc  <= pc;
            out_valid <= 1'b1;
            imem_req  <= 1'b0;
            state     <= HOLD;
          end else if (redirect) begin
            state <= FLUSH;
          end
        end
        HOLD: begin
          if (redirect || out_ready) begin
            out_valid <= 1'b0;
            if (fetch_en) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pcNext;
            end else begin
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            if (fetch_en) begin
              state     <= REQ;
              imem_addr <= pcNext;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign opcode = instr[OPCODE_HI:OPCODE_LO];
  assign rs     = instr[RS_HI:RS_LO];
  assign rt     = instr[RT_HI:RT_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign imm    = instr[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; a second instance with RESET_PC=16'hFFFF
// shares all inputs to observe PC wrap-around.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetchEn;
  logic        redirect;
  logic [15:0] redirectPc;
  logic        imemAck;
  logic [15:0] imemRdata;
  logic        outReady;

  logic        imemReq, outValid;
  logic [15:0] imemAddr, instr, instrPc;
  logic [1:0]  opcode, rs, rt, rd;
  logic [7:0]  imm;

  logic        imemReqB, outValidB;
  logic [15:0] imemAddrB, instrB, instrPcB;
  logic [1:0]  opcodeB, rsB, rtB, rdB;
  logic [7:0]  immB;

  int compareCount = 0;
  int failCount    = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .reset(reset), .fetch_en(fetchEn), .redirect(redirect),
    .redirect_pc(redirectPc), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_ack(imemAck), .imem_rdata(imemRdata), .out_valid(outValid),
    .out_ready(outReady), .instr(instr), .instr_pc(instrPc), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm)
  );

  instr_fetch #(.RESET_PC(16'hFFFF)) dutWrap (
    .clk(clk), .reset(reset), .fetch_en(fetchEn), .redirect(redirect),
    .redirect_pc(redirectPc), .imem_req(imemReqB), .imem_addr(imemAddrB),
    .imem_ack(imemAck), .imem_rdata(imemRdata), .out_valid(outValidB),
    .out_ready(outReady), .instr(instrB), .instr_pc(instrPcB), .opcode(opcodeB),
    .rs(rsB), .rt(rtB), .rd(rdB), .imm(immB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rdr, input logic [15:0] rpc,
                               input logic ack, input logic [15:0] rdata,
                               input logic rdy);
    fetchEn    = fe;
    redirect   = rdr;
    redirectPc = rpc;
    imemAck    = ack;
    imemRdata  = rdata;
    outReady   = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 16'h0, 0, 16'h0, 0);
    tick();
    tick();
    checkOutput("rstReq", 32'(imemReq), 0);
    checkOutput("rstValid", 32'(outValid), 0);
    checkOutput("rstAddr", 32'(imemAddr), 'h0);
    checkOutput("rstInstr", 32'(instr), 'h0);
    checkOutput("rstInstrPc", 32'(instrPc), 'h0);
    checkOutput("rstAddrWrap", 32'(imemAddrB), 'hFFFF);
    reset = 1'b0;

    // Zero-wait fetch of 16'h1234 from address 0
    applyStimulus(1, 0, 16'h0, 0, 16'h0, 0);
    tick();
    checkOutput("t1Req", 32'(imemReq), 1);
    checkOutput("t1Addr", 32'(imemAddr), 'h0);
    checkOutput("t1AddrWrap", 32'(imemAddrB), 'hFFFF);
    applyStimulus(1, 0, 16'h0, 1, 16'h1234, 0);
    tick();
    checkOutput("t1Valid", 32'(outValid), 1);
    checkOutput("t1Instr", 32'(instr), 'h1234);
    checkOutput("t1Opcode", 32'(opcode), 'h0);
    checkOutput("t1Rs", 32'(rs), 'h1);
    checkOutput("t1Rt", 32'(rt), 'h0);
    checkOutput("t1Rd", 32'(rd), 'h2);
    checkOutput("t1Imm", 32'(imm), 'h34);
    checkOutput("t1InstrPc", 32'(instrPc), 'h0);
    checkOutput("t1ReqDrop", 32'(imemReq), 0);
    checkOutput("t1InstrPcWrap", 32'(instrPcB), 'hFFFF);
    applyStimulus(1, 0, 16'h0, 0, 16'h0, 1);
    tick();
    checkOutput("t1Accept", 32'(outValid), 0);
    checkOutput("t1NextReq", 32'(imemReq), 1);
    checkOutput("t1NextAddr", 32'(imemAddr), 'h1);
    checkOutput("t6WrapAddr", 32'(imemAddrB), 'h0);

    // Ack delayed three cycles
    applyStimulus(1, 0, 16'h0, 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t2HoldReq", 32'(imemReq), 1);
      checkOutput("t2HoldAddr", 32'(imemAddr), 'h1);
      checkOutput("t2NoValid", 32'(outValid), 0);
    end
    applyStimulus(1, 0, 16'h0, 1, 16'h5A0F, 0);
    tick();
    applyStimulus(1, 0, 16'h0, 0, 16'h0, 0);
    checkOutput("t2Valid", 32'(outValid), 1);
    checkOutput("t2Instr", 32'(instr), 'h5A0F);
    checkOutput("t2InstrPc", 32'(instrPc), 'h1);
    checkOutput("t2Opcode", 32'(opcode), 'h1);
    checkOutput("t2Rt", 32'(rt), 'h2);
    checkOutput("t2Imm", 32'(imm), 'h0F);

    // Decode stalls for four cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t3Valid", 32'(outValid), 1);
      checkOutput("t3Instr", 32'(instr), 'h5A0F);
      checkOutput("t3NoReq", 32'(imemReq), 0);
    end
    applyStimulus(1, 0, 16'h0, 0, 16'h0, 1);
    tick();
    checkOutput("t3Accept", 32'(outValid), 0);
    checkOutput("t3Req", 32'(imemReq), 1);
    checkOutput("t3Addr", 32'(imemAddr), 'h2);

    // Redirect while a request is outstanding
    applyStimulus(1, 1, 16'h0040, 0, 16'h0, 0);
    tick();
    checkOutput("t4FlushReq", 32'(imemReq), 1);
    checkOutput("t4FlushAddr", 32'(imemAddr), 'h2);
    applyStimulus(1, 0, 16'h0, 0, 16'h0, 0);
    tick();
    checkOutput("t4WaitReq", 32'(imemReq), 1);
    checkOutput("t4WaitAddr", 32'(imemAddr), 'h2);
    checkOutput("t4WaitValid", 32'(outValid), 0);
    applyStimulus(1, 0, 16'h0, 1, 16'hDEAD, 0);
    tick();
    checkOutput("t4Dropped", 32'(outValid), 0);
    checkOutput("t4Req", 32'(imemReq), 1);
    checkOutput("t4Target", 32'(imemAddr), 'h40);

    // Redirect coincident with ack
    applyStimulus(1, 1, 16'h0080, 1, 16'hBEEF, 0);
    tick();
    checkOutput("t5aDropped", 32'(outValid), 0);
    checkOutput("t5aReq", 32'(imemReq), 1);
    checkOutput("t5aTarget", 32'(imemAddr), 'h80);
    applyStimulus(1, 0, 16'h0, 1, 16'h8123, 0);
    tick();
    checkOutput("t5aValid", 32'(outValid), 1);
    checkOutput("t5aInstr", 32'(instr), 'h8123);
    checkOutput("t5aInstrPc", 32'(instrPc), 'h80);
    checkOutput("t5aOpcode", 32'(opcode), 'h2);

    // Redirect in HOLD squashes even with decode ready
    applyStimulus(1, 1, 16'h0100, 0, 16'h0, 1);
    tick();
    checkOutput("t5bSquash", 32'(outValid), 0);
    checkOutput("t5bReq", 32'(imemReq), 1);
    checkOutput("t5bTarget", 32'(imemAddr), 'h100);

    // fetch_en low: in-flight fetch completes, then idle
    applyStimulus(0, 0, 16'h0, 1, 16'hC3FF, 0);
    tick();
    checkOutput("feValid", 32'(outValid), 1);
    checkOutput("feInstrPc", 32'(instrPc), 'h100);
    checkOutput("feOpcode", 32'(opcode), 'h3);
    applyStimulus(0, 0, 16'h0, 0, 16'h0, 1);
    tick();
    checkOutput("feIdleValid", 32'(outValid), 0);
    checkOutput("feIdleReq", 32'(imemReq), 0);
    applyStimulus(0, 0, 16'h0, 1, 16'h1111, 0);
    tick();
    checkOutput("idleAckValid", 32'(outValid), 0);
    checkOutput("idleAckReq", 32'(imemReq), 0);
    checkOutput("idleAckInstr", 32'(instr), 'hC3FF);

    // Reset asserted mid-request
    applyStimulus(1, 0, 16'h0, 0, 16'h0, 0);
    tick();
    checkOutput("t6Req", 32'(imemReq), 1);
    checkOutput("t6Addr", 32'(imemAddr), 'h101);
    reset = 1'b1;
    tick();
    checkOutput("t6RstReq", 32'(imemReq), 0);
    checkOutput("t6RstValid", 32'(outValid), 0);
    checkOutput("t6RstAddr", 32'(imemAddr), 'h0);
    checkOutput("t6RstAddrWrap", 32'(imemAddrB), 'hFFFF);
    reset = 1'b0;
    applyStimulus(0, 0, 16'h0, 1, 16'h2222, 0);
    tick();
    checkOutput("t6LateAckValid", 32'(outValid), 0);
    checkOutput("t6LateAckReq", 32'(imemReq), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
